// File: rtl/fft_input_loader.sv
// Streams one frame of 2**CMD_WIDTH samples into the FFT sample RAM
// at bit-reversed addresses, then holds until the FFT core re-arms it.
module fft_input_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int CMD_WIDTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  S_VALID,
  output logic                  S_READY,
  input  logic [DATA_WIDTH-1:0] S_DATA,
  input  logic                  S_LAST,
  output logic                  ENA,
  output logic                  WEA,
  output logic [CMD_WIDTH-1:0]  ADDRA,
  output logic [DATA_WIDTH-1:0] DIA,
  output logic                  FRAME_DONE,
  input  logic                  FRAME_ACK,
  output logic                  FRAME_ERR,
  output logic [7:0]            FRAME_CNT
);

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t                state, state_n;
  logic [CMD_WIDTH-1:0]  idx, idx_n;
  logic                  ready_n;
  logic                  ena_n;
  logic                  wea_n;
  logic [CMD_WIDTH-1:0]  addra_n;
  logic [DATA_WIDTH-1:0] dia_n;
  logic                  done_n;
  logic                  err_n;
  logic [7:0]            cnt_n;
  logic                  beat;
  logic                  is_last;

  function automatic logic [CMD_WIDTH-1:0] bitrev(
    input logic [CMD_WIDTH-1:0] v
  );
    logic [CMD_WIDTH-1:0] r;
    for (int k = 0; k < CMD_WIDTH; k++)
      r[k] = v[CMD_WIDTH-1-k];
    return r;
  endfunction

  assign beat    = S_VALID & S_READY;
  assign is_last = &idx;

  // Next-state and next-output decode; all outputs come from registers.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    ready_n = S_READY;
    ena_n   = 1'b0;
    wea_n   = 1'b0;
    addra_n = ADDRA;
    dia_n   = DIA;
    done_n  = FRAME_DONE;
    err_n   = 1'b0;
    cnt_n   = FRAME_CNT;
    unique case (state)
      LOAD: begin
        if (beat) begin
          ena_n   = 1'b1;
          wea_n   = 1'b1;
          addra_n = bitrev(idx);
          dia_n   = S_DATA;
          idx_n   = idx + 1'b1;
          err_n   = S_LAST != is_last;
          if (is_last) begin
            state_n = FULL;
            ready_n = 1'b0;
          end
        end
      end
      FULL: begin
        if (!FRAME_DONE) begin
          done_n = 1'b1;
          cnt_n  = FRAME_CNT + 8'd1;
        end else if (FRAME_ACK) begin
          state_n = LOAD;
          done_n  = 1'b0;
          ready_n = 1'b1;
        end
      end
      default: state_n = LOAD;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= LOAD;
      idx        <= '0;
      S_READY    <= 1'b1;
      ENA        <= 1'b0;
      WEA        <= 1'b0;
      ADDRA      <= '0;
      DIA        <= '0;
      FRAME_DONE <= 1'b0;
      FRAME_ERR  <= 1'b0;
      FRAME_CNT  <= 8'd0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      S_READY    <= ready_n;
      ENA        <= ena_n;
      WEA        <= wea_n;
      ADDRA      <= addra_n;
      DIA        <= dia_n;
      FRAME_DONE <= done_n;
      FRAME_ERR  <= err_n;
      FRAME_CNT  <= cnt_n;
    end
  end

endmodule

// File: tb/tb_fft_input_loader.sv
// Bench for fft_input_loader: directed vector tables plus random
// traffic compared against a frame-level behavioural model.
module tb_fft_input_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        s_last;
  logic        ena;
  logic        wea;
  logic [3:0]  addra;
  logic [15:0] dia;
  logic        frame_done;
  logic        frame_ack;
  logic        frame_err;
  logic [7:0]  frame_cnt;

  int checks = 0;
  int errors = 0;

  logic [15:0] ram [16];

  // model state
  bit          m_ready;
  int          m_pos;
  bit          m_done;
  int          m_cnt;
  bit          m_we;
  int          m_addr;
  logic [15:0] m_data;
  bit          m_err;

  typedef struct {
    logic [15:0] data;
    logic        last;
    logic [3:0]  addr;
  } vec_t;

  vec_t tbl [16];

  fft_input_loader #(
    .DATA_WIDTH(16),
    .CMD_WIDTH (4)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .S_VALID   (s_valid),
    .S_READY   (s_ready),
    .S_DATA    (s_data),
    .S_LAST    (s_last),
    .ENA       (ena),
    .WEA       (wea),
    .ADDRA     (addra),
    .DIA       (dia),
    .FRAME_DONE(frame_done),
    .FRAME_ACK (frame_ack),
    .FRAME_ERR (frame_err),
    .FRAME_CNT (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (ena && wea) ram[addra] <= dia;

  function automatic int rev4(input int v);
    int r = 0;
    for (int k = 0; k < 4; k++)
      r = r * 2 + ((v >> k) & 1);
    return r;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_ready = 1; m_pos = 0; m_done = 0; m_cnt = 0;
      m_we = 0; m_addr = 0; m_data = 0; m_err = 0;
    end else begin
      m_we  = 0;
      m_err = 0;
      if (m_ready) begin
        if (s_valid) begin
          m_we   = 1;
          m_addr = rev4(m_pos);
          m_data = s_data;
          m_err  = (s_last != (m_pos == 15));
          m_pos  = (m_pos + 1) % 16;
          if (m_pos == 0) m_ready = 0;
        end
      end else if (!m_done) begin
        m_done = 1;
        m_cnt  = (m_cnt + 1) % 256;
      end else if (frame_ack) begin
        m_done  = 0;
        m_ready = 1;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("model", {s_ready, ena, wea, addra, dia,
                  frame_done, frame_err, frame_cnt},
        {m_ready, m_we, m_we, 4'(m_addr), m_data,
         m_done, m_err, 8'(m_cnt)});
  endtask

  task automatic beat(input logic [15:0] d,
                      input logic l);
    s_valid = 1; s_data = d; s_last = l;
    step();
    s_valid = 0;
  endtask

  task automatic idle();
    s_valid = 0;
    step();
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_ready"}, 32'(s_ready), 1);
    chk({name, "_ena"},   32'(ena), 0);
    chk({name, "_wea"},   32'(wea), 0);
    chk({name, "_addra"}, 32'(addra), 0);
    chk({name, "_dia"},   32'(dia), 0);
    chk({name, "_done"},  32'(frame_done), 0);
    chk({name, "_err"},   32'(frame_err), 0);
    chk({name, "_cnt"},   32'(frame_cnt), 0);
  endtask

  task automatic table_frame(input string name);
    for (int i = 0; i < 16; i++) begin
      beat(tbl[i].data, tbl[i].last);
      chk({name, "_wea"},   32'(wea), 1);
      chk({name, "_addra"}, 32'(addra), 32'(tbl[i].addr));
      chk({name, "_dia"},   32'(dia), 32'(tbl[i].data));
      chk({name, "_err"},   32'(frame_err), 0);
    end
  endtask

  initial begin
    int order [16];
    order = '{0, 8, 4, 12, 2, 10, 6, 14,
              1, 9, 5, 13, 3, 11, 7, 15};
    for (int i = 0; i < 16; i++) begin
      tbl[i].data = 16'(i);
      tbl[i].last = (i == 15);
      tbl[i].addr = 4'(order[i]);
    end

    s_valid = 0; s_data = 0; s_last = 0;
    frame_ack = 0; rst_n = 0;

    // 1: reset
    repeat (3) step();
    rst_n = 1;
    #1;
    chk_reset("rst");
    idle();
    chk_reset("rst_idle");

    // 2: back-to-back frame
    table_frame("t2");
    chk("t2_ready_off", 32'(s_ready), 0);
    chk("t2_done_early", 32'(frame_done), 0);
    idle();
    chk("t2_done", 32'(frame_done), 1);
    chk("t2_cnt", 32'(frame_cnt), 1);
    chk("t2_wea_off", 32'(wea), 0);
    chk("t2_ram8", 32'(ram[8]), 1);
    frame_ack = 1;
    idle();
    frame_ack = 0;
    chk("t2_rearm", 32'(s_ready), 1);
    chk("t2_done_clr", 32'(frame_done), 0);

    // 3: gapped frame, then 4: early ack
    for (int i = 0; i < 16; i++) begin
      beat(16'(100 + i), i == 15);
      chk("t3_addra", 32'(addra), 32'(order[i]));
      chk("t3_dia", 32'(dia), 32'(100 + i));
      if (i < 15) begin
        idle();
        chk("t3_gap_wea", 32'(wea), 0);
        chk("t3_gap_addr", 32'(addra), 32'(order[i]));
      end
    end
    chk("t3_ready_off", 32'(s_ready), 0);
    frame_ack = 1;
    idle();
    chk("t4_early_ack", 32'(s_ready), 0);
    chk("t4_done", 32'(frame_done), 1);
    chk("t4_cnt", 32'(frame_cnt), 2);
    idle();
    frame_ack = 0;
    chk("t4_rearm", 32'(s_ready), 1);

    // 5: misplaced S_LAST
    for (int i = 0; i < 16; i++) begin
      beat(16'(200 + i), i == 5);
      if (i == 0) chk("t4_first_addr", 32'(addra), 0);
      chk("t5_err", 32'(frame_err),
          32'((i == 5) || (i == 15)));
    end
    idle();
    chk("t5_err_clr", 32'(frame_err), 0);
    chk("t5_done", 32'(frame_done), 1);
    chk("t5_cnt", 32'(frame_cnt), 3);
    frame_ack = 1;
    idle();
    frame_ack = 0;

    // 6: reset mid-frame
    for (int i = 0; i < 8; i++)
      beat(16'(300 + i), 1'b0);
    rst_n = 0;
    idle();
    rst_n = 1;
    chk_reset("t6_rst");
    table_frame("t6");
    idle();
    chk("t6_cnt", 32'(frame_cnt), 1);
    frame_ack = 1;
    idle();
    frame_ack = 0;

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      s_valid   = ($urandom_range(0, 3) != 0);
      s_data    = 16'($urandom);
      s_last    = ($urandom_range(0, 7) == 0);
      frame_ack = ($urandom_range(0, 1) == 1);
      rst_n     = ($urandom_range(0, 149) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
